// File: rtl/uart_reg_ctrl.sv
// ============================================================================
//  uart_reg_ctrl : bus-side controller for the 16550-style UART register bank
//  Optional feature macro: UART_SCRATCH_EN (offset-7 scratch register)
//  Revision: 1.0
// ============================================================================
`default_nettype none

module uart_reg_ctrl #(
   parameter int            DW        = 8,
   parameter logic [DW-1:0] EMPTY_VAL = {DW{1'b0}}
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [2:0]    req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_rdata,
   input  logic [DW-1:0] lcr_q,
   input  logic [DW-1:0] ier_q,
   input  logic [DW-1:0] mcr_q,
   input  logic [DW-1:0] dll_q,
   input  logic [DW-1:0] dlm_q,
   input  logic [DW-1:0] iir_in,
   input  logic [DW-1:0] lsr_in,
   input  logic [DW-1:0] msr_in,
   input  logic [DW-1:0] rx_data,
   input  logic          rx_empty,
   input  logic          tx_full,
   output logic [DW-1:0] reg_d,
   output logic          ce_ier,
   output logic          ce_lcr,
   output logic          ce_mcr,
   output logic          ce_dll,
   output logic          ce_dlm,
   output logic          ce_fcr,
   output logic          tx_push,
   output logic          rx_pop,
   output logic          iir_rd,
   output logic          lsr_rd,
   output logic          msr_rd
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WR   = 2'd1,
      ST_RD   = 2'd2,
      ST_RSP  = 2'd3
   } state_e;

   localparam int c_b_ier = 10;
   localparam int c_b_lcr = 9;
   localparam int c_b_mcr = 8;
   localparam int c_b_dll = 7;
   localparam int c_b_dlm = 6;
   localparam int c_b_fcr = 5;
   localparam int c_b_txp = 4;
   localparam int c_b_rxp = 3;
   localparam int c_b_iir = 2;
   localparam int c_b_lsr = 1;
   localparam int c_b_msr = 0;

   state_e        state_q, state_d;
   logic [10:0]   strb_q, strb_d;
   logic [2:0]    addr_q;
   logic          dlab_q;
   logic [DW-1:0] reg_d_q;
   logic [DW-1:0] rdata_q, rdata_d;
   logic [DW-1:0] w_scratch;

   // Strobes are decoded at the accept edge so they appear, registered,
   // exactly during the single WR/RD cycle that follows.
   always_comb begin
      state_d = state_q;
      strb_d  = '0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               state_d = req_we ? ST_WR : ST_RD;
               if (req_we) begin
                  case (req_addr)
                     3'd0: begin
                        if (lcr_q[7])      strb_d[c_b_dll] = 1'b1;
                        else if (!tx_full) strb_d[c_b_txp] = 1'b1;
                     end
                     3'd1: begin
                        if (lcr_q[7]) strb_d[c_b_dlm] = 1'b1;
                        else          strb_d[c_b_ier] = 1'b1;
                     end
                     3'd2:    strb_d[c_b_fcr] = 1'b1;
                     3'd3:    strb_d[c_b_lcr] = 1'b1;
                     3'd4:    strb_d[c_b_mcr] = 1'b1;
                     default: ;
                  endcase
               end else begin
                  case (req_addr)
                     3'd0:    strb_d[c_b_rxp] = !lcr_q[7] && !rx_empty;
                     3'd2:    strb_d[c_b_iir] = 1'b1;
                     3'd5:    strb_d[c_b_lsr] = 1'b1;
                     3'd6:    strb_d[c_b_msr] = 1'b1;
                     default: ;
                  endcase
               end
            end
         end
         ST_WR:   state_d = ST_RSP;
         ST_RD:   state_d = ST_RSP;
         ST_RSP:  if (rsp_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Read data is sampled at the end of RD, i.e. on the same edge the
   // side-effect strobe takes effect in the core.
   always_comb begin
      rdata_d = rdata_q;
      if (state_q == ST_WR) begin
         rdata_d = '0;
      end else if (state_q == ST_RD) begin
         case (addr_q)
            3'd0: rdata_d = dlab_q ? dll_q : (rx_empty ? EMPTY_VAL : rx_data);
            3'd1: rdata_d = dlab_q ? dlm_q : ier_q;
            3'd2: rdata_d = iir_in;
            3'd3: rdata_d = lcr_q;
            3'd4: rdata_d = mcr_q;
            3'd5: rdata_d = lsr_in;
            3'd6: rdata_d = msr_in;
            3'd7: rdata_d = w_scratch;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         strb_q  <= '0;
         addr_q  <= '0;
         dlab_q  <= 1'b0;
         reg_d_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         strb_q  <= strb_d;
         rdata_q <= rdata_d;
         if (state_q == ST_IDLE && req_valid) begin
            addr_q <= req_addr;
            dlab_q <= lcr_q[7];
            if (req_we) reg_d_q <= req_wdata;
         end
      end
   end

`ifdef UART_SCRATCH_EN
   logic [DW-1:0] scratch_q;

   always_ff @(posedge clk) begin
      if (rst)                                     scratch_q <= '0;
      else if (state_q == ST_WR && addr_q == 3'd7) scratch_q <= reg_d_q;
   end

   assign w_scratch = scratch_q;
`else
   assign w_scratch = '0;
`endif

   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = (state_q == ST_RSP);
   assign rsp_rdata = rdata_q;
   assign reg_d     = reg_d_q;

   assign ce_ier  = strb_q[c_b_ier];
   assign ce_lcr  = strb_q[c_b_lcr];
   assign ce_mcr  = strb_q[c_b_mcr];
   assign ce_dll  = strb_q[c_b_dll];
   assign ce_dlm  = strb_q[c_b_dlm];
   assign ce_fcr  = strb_q[c_b_fcr];
   assign tx_push = strb_q[c_b_txp];
   assign rx_pop  = strb_q[c_b_rxp];
   assign iir_rd  = strb_q[c_b_iir];
   assign lsr_rd  = strb_q[c_b_lsr];
   assign msr_rd  = strb_q[c_b_msr];

endmodule

`default_nettype wire

// File: tb/tb_uart_reg_ctrl.sv
// ============================================================================
//  tb_uart_reg_ctrl : scoreboard bench for uart_reg_ctrl (directed vectors)
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uart_reg_ctrl;

   localparam logic [10:0] S_IER = 11'b100_0000_0000;
   localparam logic [10:0] S_LCR = 11'b010_0000_0000;
   localparam logic [10:0] S_MCR = 11'b001_0000_0000;
   localparam logic [10:0] S_DLL = 11'b000_1000_0000;
   localparam logic [10:0] S_DLM = 11'b000_0100_0000;
   localparam logic [10:0] S_FCR = 11'b000_0010_0000;
   localparam logic [10:0] S_TXP = 11'b000_0001_0000;
   localparam logic [10:0] S_RXP = 11'b000_0000_1000;
   localparam logic [10:0] S_IIR = 11'b000_0000_0100;
   localparam logic [10:0] S_LSR = 11'b000_0000_0010;
   localparam logic [10:0] S_MSR = 11'b000_0000_0001;
   localparam logic [10:0] S_NONE = 11'b0;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic       req_we = 1'b0;
   logic [2:0] req_addr = 3'd0;
   logic [7:0] req_wdata = 8'h00;
   logic       rsp_valid;
   logic       rsp_ready = 1'b1;
   logic [7:0] rsp_rdata;
   logic [7:0] lcr_q = 8'h00, ier_q = 8'h00, mcr_q = 8'h00, dll_q = 8'h00, dlm_q = 8'h00;
   logic [7:0] iir_in = 8'hC1, lsr_in = 8'h60, msr_in = 8'hB0, rx_data = 8'h5A;
   logic       rx_empty = 1'b1;
   logic       tx_full = 1'b0;
   logic [7:0] reg_d;
   logic       ce_ier, ce_lcr, ce_mcr, ce_dll, ce_dlm, ce_fcr;
   logic       tx_push, rx_pop, iir_rd, lsr_rd, msr_rd;
   logic [10:0] strb;

   uart_reg_ctrl #(.DW(8), .EMPTY_VAL(8'h00)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .lcr_q(lcr_q), .ier_q(ier_q), .mcr_q(mcr_q), .dll_q(dll_q), .dlm_q(dlm_q),
      .iir_in(iir_in), .lsr_in(lsr_in), .msr_in(msr_in),
      .rx_data(rx_data), .rx_empty(rx_empty), .tx_full(tx_full),
      .reg_d(reg_d),
      .ce_ier(ce_ier), .ce_lcr(ce_lcr), .ce_mcr(ce_mcr),
      .ce_dll(ce_dll), .ce_dlm(ce_dlm), .ce_fcr(ce_fcr),
      .tx_push(tx_push), .rx_pop(rx_pop),
      .iir_rd(iir_rd), .lsr_rd(lsr_rd), .msr_rd(msr_rd)
   );

   assign strb = {ce_ier, ce_lcr, ce_mcr, ce_dll, ce_dlm, ce_fcr,
                  tx_push, rx_pop, iir_rd, lsr_rd, msr_rd};

   always #5 clk = ~clk;

   // Register bank model: clock-enabled registers load the shared write data
   always @(posedge clk) begin
      if (ce_lcr) lcr_q <= reg_d;
      if (ce_ier) ier_q <= reg_d;
      if (ce_mcr) mcr_q <= reg_d;
      if (ce_dll) dll_q <= reg_d;
      if (ce_dlm) dlm_q <= reg_d;
   end

   typedef struct {
      logic [7:0]  rdata;
      logic [10:0] strb;
      logic [7:0]  regd;
   } exp_t;

   exp_t sb_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   done_cnt = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Monitor: accumulates strobes seen since the last response and checks
   // them, plus the read data, against the scoreboard at each handshake.
   initial begin
      logic [10:0] acc;
      int          cnt;
      logic [7:0]  regd_seen;
      exp_t        e;
      acc = '0; cnt = 0; regd_seen = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            acc = '0; cnt = 0; regd_seen = '0;
         end else begin
            if (strb != 11'b0) begin
               acc |= strb;
               cnt++;
               if (strb[10:4] != 7'b0) regd_seen = reg_d;
            end
            if (rsp_valid && rsp_ready) begin
               if (sb_q.size() == 0) begin
                  chk("unexpected_rsp", 32'd1, 32'd0);
               end else begin
                  e = sb_q.pop_front();
                  chk("rsp_rdata", {24'b0, rsp_rdata}, {24'b0, e.rdata});
                  chk("strobes", {21'b0, acc}, {21'b0, e.strb});
                  chk("strobe_cycles", cnt, (e.strb != 11'b0) ? 1 : 0);
                  if (e.strb[10:4] != 7'b0)
                     chk("reg_d", {24'b0, regd_seen}, {24'b0, e.regd});
               end
               acc = '0; cnt = 0;
               done_cnt++;
            end
         end
      end
   end

   // Present a request and return 1 time unit after the accepting edge.
   task automatic issue(input logic we, input logic [2:0] a, input logic [7:0] wd);
      int n;
      n = 0;
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
      @(negedge clk);
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_done(input int start);
      int n;
      n = 0;
      while (done_cnt == start && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (done_cnt == start) chk("rsp_timeout", 32'd0, 32'd1);
   endtask

   task automatic access(input logic we, input logic [2:0] a, input logic [7:0] wd,
                         input logic [7:0] er, input logic [10:0] es, input logic [7:0] erd);
      int start;
      start = done_cnt;
      sb_q.push_back('{rdata: er, strb: es, regd: erd});
      issue(we, a, wd);
      wait_done(start);
   endtask

   initial begin
      int start;
      logic [7:0] exp_scr;
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int start;
      logic [7:0] exp_scr;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_rsp_rdata", {24'b0, rsp_rdata}, 32'd0);
      chk("rst_reg_d", {24'b0, reg_d}, 32'd0);
      chk("rst_strobes", {21'b0, strb}, 32'd0);
      @(posedge clk); #1;

      access(1'b1, 3'd3, 8'h03, 8'h00, S_LCR, 8'h03);

      // Latency: strobe in N+1, response from N+2
      start = done_cnt;
      sb_q.push_back('{rdata: 8'h00, strb: S_TXP, regd: 8'h41});
      issue(1'b1, 3'd0, 8'h41);
      @(negedge clk);
      chk("lat_tx_push_n1", {31'b0, tx_push}, 32'd1);
      chk("lat_reg_d_n1", {24'b0, reg_d}, 32'h41);
      chk("lat_rsp_valid_n1", {31'b0, rsp_valid}, 32'd0);
      @(negedge clk);
      chk("lat_rsp_valid_n2", {31'b0, rsp_valid}, 32'd1);
      chk("lat_tx_push_n2", {31'b0, tx_push}, 32'd0);
      @(posedge clk); #1;
      wait_done(start);

      tx_full = 1'b1;
      access(1'b1, 3'd0, 8'h99, 8'h00, S_NONE, 8'h00);
      tx_full = 1'b0;

      // Divisor latch access
      access(1'b1, 3'd3, 8'h83, 8'h00, S_LCR, 8'h83);
      access(1'b1, 3'd0, 8'h0C, 8'h00, S_DLL, 8'h0C);
      access(1'b1, 3'd1, 8'h00, 8'h00, S_DLM, 8'h00);
      rx_empty = 1'b0;
      access(1'b0, 3'd0, 8'h00, 8'h0C, S_NONE, 8'h00);
      access(1'b0, 3'd1, 8'h00, 8'h00, S_NONE, 8'h00);
      access(1'b1, 3'd3, 8'h03, 8'h00, S_LCR, 8'h03);
      access(1'b1, 3'd1, 8'h05, 8'h00, S_IER, 8'h05);
      access(1'b0, 3'd1, 8'h00, 8'h05, S_NONE, 8'h00);

      // RBR with FIFO empty and non-empty
      rx_empty = 1'b1;
      access(1'b0, 3'd0, 8'h00, 8'h00, S_NONE, 8'h00);
      rx_empty = 1'b0;
      access(1'b0, 3'd0, 8'h00, 8'h5A, S_RXP, 8'h00);
      rx_empty = 1'b1;

      access(1'b0, 3'd2, 8'h00, 8'hC1, S_IIR, 8'h00);
      access(1'b0, 3'd5, 8'h00, 8'h60, S_LSR, 8'h00);
      access(1'b0, 3'd6, 8'h00, 8'hB0, S_MSR, 8'h00);
      access(1'b0, 3'd3, 8'h00, 8'h03, S_NONE, 8'h00);
      access(1'b1, 3'd4, 8'h1F, 8'h00, S_MCR, 8'h1F);
      access(1'b0, 3'd4, 8'h00, 8'h1F, S_NONE, 8'h00);
      access(1'b1, 3'd2, 8'h07, 8'h00, S_FCR, 8'h07);
      access(1'b1, 3'd5, 8'hFF, 8'h00, S_NONE, 8'h00);
      access(1'b1, 3'd6, 8'hFF, 8'h00, S_NONE, 8'h00);

`ifdef UART_SCRATCH_EN
      exp_scr = 8'hA5;
`else
      exp_scr = 8'h00;
`endif
      access(1'b1, 3'd7, 8'hA5, 8'h00, S_NONE, 8'h00);
      access(1'b0, 3'd7, 8'h00, exp_scr, S_NONE, 8'h00);

      // Response back-pressure: held for 5 cycles with the status input moving
      rsp_ready = 1'b0;
      start = done_cnt;
      sb_q.push_back('{rdata: 8'hC1, strb: S_IIR, regd: 8'h00});
      issue(1'b0, 3'd2, 8'h00);
      @(posedge clk); #1;
      iir_in = 8'h00;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
         chk("bp_rsp_rdata", {24'b0, rsp_rdata}, 32'hC1);
         chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
         chk("bp_strobes", {21'b0, strb}, 32'd0);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_release_req_ready", {31'b0, req_ready}, 32'd1);
      chk("bp_release_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      @(posedge clk); #1;
      wait_done(start);
      iir_in = 8'hC1;

      // Reset during RD
      issue(1'b0, 3'd5, 8'h00);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rstrd_req_ready", {31'b0, req_ready}, 32'd1);
      chk("rstrd_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rstrd_rsp_rdata", {24'b0, rsp_rdata}, 32'd0);
      chk("rstrd_reg_d", {24'b0, reg_d}, 32'd0);
      chk("rstrd_strobes", {21'b0, strb}, 32'd0);
      @(posedge clk); #1;

      // Reset during RSP
      rsp_ready = 1'b0;
      issue(1'b0, 3'd3, 8'h00);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rstrsp_pre_valid", {31'b0, rsp_valid}, 32'd1);
      chk("rstrsp_pre_rdata", {24'b0, rsp_rdata}, 32'h03);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("rstrsp_req_ready", {31'b0, req_ready}, 32'd1);
      chk("rstrsp_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rstrsp_rsp_rdata", {24'b0, rsp_rdata}, 32'd0);
      chk("rstrsp_strobes", {21'b0, strb}, 32'd0);
      @(posedge clk); #1;

      access(1'b0, 3'd3, 8'h00, 8'h03, S_NONE, 8'h00);

      repeat (2) @(posedge clk);
      chk("scoreboard_drained", sb_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
